// File: rtl/tmds_decoder.sv
// Single-channel TMDS receive decoder: bit-slip alignment driven by control-token
// runs, then per-symbol decode into pixel data, control bits and data enable.
module tmds_decoder #(
  parameter int CTRL_RUN     = 16,
  parameter int SEARCH_WIN   = 4096,
  parameter int LOCK_TIMEOUT = 4096
) (
  input  logic       clk_pix,
  input  logic       rst_pix,
  input  logic [9:0] tmds_in,
  output logic [7:0] data,
  output logic [1:0] ctrl,
  output logic       de,
  output logic       locked,
  output logic [3:0] offset
);

  localparam int DW = (SEARCH_WIN > 1) ? $clog2(SEARCH_WIN) : 1;
  localparam int RW = $clog2(CTRL_RUN + 1);
  localparam int QW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

  typedef enum logic {ST_SEARCH, ST_LOCKED} state_t;

  state_t          state_q, state_d;
  logic [9:0]      prev_q, sym_q, sym_d;
  logic [3:0]      offset_q, offset_d;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic [RW-1:0]   run_q, run_d;
  logic [QW-1:0]   quiet_q, quiet_d;
  logic [7:0]      data_q, data_d;
  logic [1:0]      ctrl_q, ctrl_d;
  logic            de_q, de_d;
  logic            locked_q, locked_d;

  logic [19:0]     window;
  logic            is_ctrl;
  logic [1:0]      ctrl_val;
  logic [7:0]      dvec, dec;

  assign window = {tmds_in, prev_q};

  // Offset k takes the top bits of the previous word and the low k bits of the current one.
  always_comb begin
    sym_d = prev_q;
    for (int k = 1; k < 10; k++) begin
      if (offset_q == 4'(k)) sym_d = window[k +: 10];
    end
  end

  always_comb begin
    is_ctrl  = 1'b1;
    ctrl_val = 2'b00;
    case (sym_q)
      10'b1101010100: ctrl_val = 2'b00;
      10'b0010101011: ctrl_val = 2'b01;
      10'b0101010100: ctrl_val = 2'b10;
      10'b1010101011: ctrl_val = 2'b11;
      default:        is_ctrl  = 1'b0;
    endcase
  end

  // Undo the optional inversion, then the XOR/XNOR transition chain.
  always_comb begin
    dvec   = sym_q[9] ? ~sym_q[7:0] : sym_q[7:0];
    dec    = 8'h00;
    dec[0] = dvec[0];
    for (int i = 1; i < 8; i++) begin
      dec[i] = sym_q[8] ? (dvec[i] ^ dvec[i-1]) : ~(dvec[i] ^ dvec[i-1]);
    end
  end

  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    dwell_d  = dwell_q;
    run_d    = run_q;
    quiet_d  = quiet_q;
    case (state_q)
      ST_SEARCH: begin
        if (run_q == RW'(CTRL_RUN)) begin
          state_d = ST_LOCKED;
          quiet_d = '0;
        end else if (dwell_q == DW'(SEARCH_WIN - 1)) begin
          offset_d = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
          dwell_d  = '0;
          run_d    = '0;
        end else begin
          // Both counters are below their terminal values here, so they cannot wrap.
          dwell_d = dwell_q + 1'b1;
          run_d   = is_ctrl ? run_q + 1'b1 : '0;
        end
      end
      ST_LOCKED: begin
        if (quiet_q == QW'(LOCK_TIMEOUT - 1)) begin
          state_d = ST_SEARCH;
          dwell_d = '0;
          run_d   = '0;
        end else begin
          quiet_d = is_ctrl ? '0 : quiet_q + 1'b1;
        end
      end
      default: state_d = ST_SEARCH;
    endcase
  end

  // Outputs follow the next state so locked/de change on the same edge as the FSM.
  always_comb begin
    locked_d = (state_d == ST_LOCKED);
    data_d   = 8'h00;
    ctrl_d   = 2'b00;
    de_d     = 1'b0;
    if (locked_d) begin
      if (is_ctrl) begin
        ctrl_d = ctrl_val;
      end else begin
        de_d   = 1'b1;
        data_d = dec;
        ctrl_d = ctrl_q;
      end
    end
  end

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      state_q  <= ST_SEARCH;
      prev_q   <= '0;
      sym_q    <= '0;
      offset_q <= '0;
      dwell_q  <= '0;
      run_q    <= '0;
      quiet_q  <= '0;
      data_q   <= '0;
      ctrl_q   <= '0;
      de_q     <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= tmds_in;
      sym_q    <= sym_d;
      offset_q <= offset_d;
      dwell_q  <= dwell_d;
      run_q    <= run_d;
      quiet_q  <= quiet_d;
      data_q   <= data_d;
      ctrl_q   <= ctrl_d;
      de_q     <= de_d;
      locked_q <= locked_d;
    end
  end

  assign data   = data_q;
  assign ctrl   = ctrl_q;
  assign de     = de_q;
  assign locked = locked_q;
  assign offset = offset_q;

endmodule

// File: tb/tb_tmds_decoder.sv
// Directed-vector bench for tmds_decoder with short search/timeout windows so
// slips and lock loss happen within a few hundred cycles.
module tb_tmds_decoder;

  localparam int CTRL_RUN     = 16;
  localparam int SEARCH_WIN   = 64;
  localparam int LOCK_TIMEOUT = 32;

  logic       clk_pix = 1'b0;
  logic       rst_pix;
  logic [9:0] tmds_in;
  logic [7:0] data;
  logic [1:0] ctrl;
  logic       de;
  logic       locked;
  logic [3:0] offset;

  int totalChecks = 0;
  int badChecks   = 0;

  logic [9:0] vecIn  [5] = '{10'h100, 10'h3FF, 10'h0FF, 10'h055, 10'h1F0};
  logic [7:0] vecOut [5] = '{8'h00,   8'h00,   8'hFF,   8'h01,   8'h10};
  logic [9:0] tokTen = 10'h154;
  logic [9:0] rotWord;

  tmds_decoder #(
    .CTRL_RUN(CTRL_RUN), .SEARCH_WIN(SEARCH_WIN), .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) dut (
    .clk_pix(clk_pix), .rst_pix(rst_pix), .tmds_in(tmds_in),
    .data(data), .ctrl(ctrl), .de(de), .locked(locked), .offset(offset)
  );

  always #5 clk_pix = ~clk_pix;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_pix);
    #1;
  endtask

  task automatic applyStimulus(input logic [9:0] w);
    tmds_in = w;
  endtask

  // Leaves the bench just after the last reset edge with the given word on the input.
  task automatic doReset(input logic [9:0] w);
    rst_pix = 1'b1;
    tmds_in = w;
    tick(2);
    rst_pix = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rst_pix = 1'b1;
    tmds_in = '0;

    // Reset with random input, then an idle stream that never locks.
    tmds_in = 10'($urandom); tick(1);
    tmds_in = 10'($urandom); tick(1);
    checkOutput("rstData",   32'(data),   0);
    checkOutput("rstCtrl",   32'(ctrl),   0);
    checkOutput("rstDe",     32'(de),     0);
    checkOutput("rstLocked", 32'(locked), 0);
    checkOutput("rstOffset", 32'(offset), 0);
    rst_pix = 1'b0;
    applyStimulus(10'h000);
    for (int m = 0; m <= 10; m++) begin
      tick((m == 0) ? 32 : 64);
      checkOutput($sformatf("idleOffset%0d", m), 32'(offset), 32'(m % 10));
      checkOutput("idleUnlocked", 32'(locked), 0);
    end

    // Aligned lock on token 00, then switch to token 01.
    doReset(10'h354);
    tick(18);
    checkOutput("alignEarly",  32'(locked), 0);
    tick(1);
    checkOutput("alignLocked", 32'(locked), 1);
    checkOutput("alignOffset", 32'(offset), 0);
    checkOutput("alignDe",     32'(de),     0);
    checkOutput("alignCtrl",   32'(ctrl),   0);
    applyStimulus(10'h0AB);
    tick(2);
    checkOutput("ctrlNotYet",  32'(ctrl),   0);
    tick(1);
    checkOutput("ctrl01",      32'(ctrl),   1);

    // Data decode, three cycles from input to output.
    for (int i = 0; i < 7; i++) begin
      applyStimulus((i < 5) ? vecIn[i] : 10'h0AB);
      tick(1);
      if (i >= 2) begin
        checkOutput($sformatf("decDe%0d", i - 2),   32'(de),   1);
        checkOutput($sformatf("decData%0d", i - 2), 32'(data), 32'(vecOut[i - 2]));
        checkOutput($sformatf("decCtrl%0d", i - 2), 32'(ctrl), 1);
      end
    end
    tick(1);
    checkOutput("backToCtrlDe",   32'(de),   0);
    checkOutput("backToCtrlData", 32'(data), 0);

    // Lock loss postponed by one token 20 cycles into a data run.
    applyStimulus(10'h100);
    tick(20);
    applyStimulus(10'h0AB);
    tick(1);
    applyStimulus(10'h100);
    tick(13);
    checkOutput("postponedHeld",  32'(locked), 1);
    tick(20);
    checkOutput("postponedLast",  32'(locked), 1);
    checkOutput("postponedLastDe", 32'(de),    1);
    tick(1);
    checkOutput("postponedDrop",   32'(locked), 0);
    checkOutput("postponedDropDe", 32'(de),     0);
    checkOutput("postponedOffset", 32'(offset), 0);

    // Relock at the kept offset, then drop after a pure data run.
    applyStimulus(10'h354);
    n = 0;
    while (!locked && n < 25) begin
      tick(1);
      n++;
    end
    checkOutput("relock",       32'(locked), 1);
    checkOutput("relockOffset", 32'(offset), 0);
    applyStimulus(10'h100);
    tick(33);
    checkOutput("lossHeld",   32'(locked), 1);
    tick(1);
    checkOutput("lossDrop",   32'(locked), 0);
    checkOutput("lossDe",     32'(de),     0);
    checkOutput("lossOffset", 32'(offset), 0);
    tick(64);
    checkOutput("searchResumed", 32'(offset), 1);

    // Misaligned stream: token 10 rotated so that offset 3 recovers it.
    rotWord = {tokTen[6:0], tokTen[9:7]};
    doReset(rotWord);
    n = 0;
    while (!locked && n < 230) begin
      tick(1);
      n++;
    end
    checkOutput("misLockCycles", 32'(n),      210);
    checkOutput("misLocked",     32'(locked), 1);
    checkOutput("misOffset",     32'(offset), 3);
    checkOutput("misCtrl",       32'(ctrl),   2);
    checkOutput("misDe",         32'(de),     0);

    // Reset in the middle of a search.
    doReset(10'h000);
    tick(330);
    checkOutput("midOffset5", 32'(offset), 5);
    rst_pix = 1'b1;
    tick(1);
    checkOutput("midRstOffset", 32'(offset), 0);
    checkOutput("midRstLocked", 32'(locked), 0);
    rst_pix = 1'b0;

    // Sixteenth token coincides with the last dwell cycle: lock wins, no slip.
    tick(45);
    applyStimulus(10'h354);
    tick(17);
    checkOutput("prioBefore",  32'(locked), 0);
    tick(1);
    checkOutput("prioBefore2", 32'(locked), 0);
    tick(1);
    checkOutput("prioLocked",  32'(locked), 1);
    checkOutput("prioOffset",  32'(offset), 0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
